// File: rtl/axis_fifo_bram_ctrl.sv
// AXI-Stream FIFO controller driving an external simple dual-port BRAM
// (1-cycle registered read), with a 2-entry output buffer hiding read latency.
module axis_fifo_bram_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       bram_wea,
    output logic [ADDRESS_WIDTH-1:0]   bram_addra,
    output logic [DATA_WIDTH-1:0]      bram_dina,
    output logic                       bram_reb,
    output logic [ADDRESS_WIDTH-1:0]   bram_addrb,
    input  logic [DATA_WIDTH-1:0]      bram_doutb,
    output logic [ADDRESS_WIDTH+1:0]   level
);
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_C = ADDRESS_WIDTH'(1) << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = 1;

    logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDRESS_WIDTH:0]   ram_count, ram_count_next;
    logic                     inflight;
    logic [1:0]               out_cnt;
    logic [DATA_WIDTH-1:0]    head, skid;
    logic                     push, pop, issue;

    assign push = s_axis_tvalid & s_axis_tready;
    assign pop  = m_axis_tvalid & m_axis_tready;

    // Buffered + in-flight words minus this cycle's pop must leave room for one more.
    assign issue = !reset && (ram_count != '0) &&
                   (({1'b0, out_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    assign bram_wea      = push & !reset;
    assign bram_addra    = wr_ptr;
    assign bram_dina     = s_axis_tdata;
    assign bram_reb      = issue;
    assign bram_addrb    = rd_ptr;
    assign m_axis_tvalid = (out_cnt != 2'd0);
    assign m_axis_tdata  = head;

    always_comb begin
        ram_count_next = ram_count;
        if (push && !issue)
            ram_count_next = ram_count + CNT_ONE;
        else if (!push && issue)
            ram_count_next = ram_count - CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ram_count     <= '0;
            inflight      <= 1'b0;
            s_axis_tready <= 1'b0;
            level         <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (issue)
                rd_ptr <= rd_ptr + PTR_ONE;
            ram_count     <= ram_count_next;
            inflight      <= issue;
            s_axis_tready <= (ram_count_next != DEPTH_C);
            level         <= level + {{(ADDRESS_WIDTH+1){1'b0}}, push}
                                   - {{(ADDRESS_WIDTH+1){1'b0}}, pop};
        end
    end

    // inflight means bram_doutb carries a word this cycle that must land in the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_cnt <= 2'd0;
            head    <= '0;
            skid    <= '0;
        end else if (inflight && pop) begin
            if (out_cnt == 2'd2) begin
                head <= skid;
                skid <= bram_doutb;
            end else begin
                head <= bram_doutb;
            end
        end else if (inflight) begin
            if (out_cnt == 2'd0)
                head <= bram_doutb;
            else
                skid <= bram_doutb;
            out_cnt <= out_cnt + 2'd1;
        end else if (pop) begin
            head    <= skid;
            out_cnt <= out_cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_axis_fifo_bram_ctrl.sv
// Bench for axis_fifo_bram_ctrl: BRAM model, scoreboard queue and directed/random traffic.
module tb_axis_fifo_bram_ctrl;
    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          bram_wea, bram_reb;
    logic [AW-1:0] bram_addra, bram_addrb;
    logic [DW-1:0] bram_dina, bram_doutb;
    logic [AW+1:0] level;

    axis_fifo_bram_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_reb(bram_reb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
        .level(level)
    );

    always #5 clk = ~clk;

    // External simple dual-port BRAM with registered read port.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_wea) mem[bram_addra] <= bram_dina;
        if (bram_reb) bram_doutb <= mem[bram_addrb];
    end

    int compared   = 0;
    int mismatched = 0;
    logic [DW-1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor sampled mid-cycle: scoreboard, level tracking, stall stability, address clash.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            chk("level_vs_scoreboard", 32'(level), 32'(sb.size()));
            if (bram_wea && bram_reb)
                chk("rdw_addr_clash", 32'(bram_addra == bram_addrb), 32'd0);
            if (stall_prev) begin
                chk("tdata_stable", 32'(m_axis_tdata), 32'(held));
                chk("tvalid_stable", 32'(m_axis_tvalid), 32'd1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0)
                    chk("pop_nonempty", 32'(sb.size() != 0), 32'd1);
                else
                    chk("out_data", 32'(m_axis_tdata), 32'(sb.pop_front()));
            end
            if (s_axis_tvalid && s_axis_tready)
                sb.push_back(s_axis_tdata);
            stall_prev = m_axis_tvalid & !m_axis_tready;
            held       = m_axis_tdata;
        end
    end

    task automatic wait_empty(input int bound);
        int n = 0;
        while ((m_axis_tvalid || sb.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_in_time", 32'(n < bound), 32'd1);
    endtask

    initial begin
        int sent, recv, first, last, cyc, wraps, n, accepted;
        logic pushed, popped;
        logic [DW-1:0] dat;

        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_wea", 32'(bram_wea), 32'd0);
        chk("rst_reb", 32'(bram_reb), 32'd0);
        #2 reset = 1'b0;
        tick();
        chk("ready_after_reset", 32'(s_axis_tready), 32'd1);

        // Single word latency
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'hA5A5;
        tick();
        s_axis_tvalid = 1'b0;
        chk("single_level_1", 32'(level), 32'd1);
        chk("single_reb", 32'(bram_reb), 32'd1);
        chk("single_addrb", 32'(bram_addrb), 32'd0);
        chk("single_tvalid_e0", 32'(m_axis_tvalid), 32'd0);
        tick();
        chk("single_tvalid_e1", 32'(m_axis_tvalid), 32'd0);
        tick();
        chk("single_tvalid_e2", 32'(m_axis_tvalid), 32'd1);
        chk("single_tdata", 32'(m_axis_tdata), 32'hA5A5);
        tick();
        chk("single_tvalid_after_pop", 32'(m_axis_tvalid), 32'd0);
        chk("single_level_0", 32'(level), 32'd0);
        chk("single_s_tready", 32'(s_axis_tready), 32'd1);

        // Fill to capacity with output stalled
        m_axis_tready = 1'b0; accepted = 0;
        for (int i = 0; i < 40; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(accepted);
            pushed = s_axis_tready;
            tick();
            if (pushed) accepted++;
        end
        s_axis_tvalid = 1'b0;
        chk("fill_accepted", 32'(accepted), 32'd34);
        chk("fill_s_tready", 32'(s_axis_tready), 32'd0);
        chk("fill_level", 32'(level), 32'd34);
        m_axis_tready = 1'b1;
        wait_empty(200);
        chk("fill_ready_back", 32'(s_axis_tready), 32'd1);
        chk("fill_level_0", 32'(level), 32'd0);

        // Streaming, both sides ready
        sent = 0; recv = 0; first = -1; last = 0; cyc = 0; wraps = 0;
        while ((sent < 100 || recv < 100) && cyc < 400) begin
            s_axis_tvalid = (sent < 100);
            s_axis_tdata  = DW'(16'h0100 + sent);
            #0;
            pushed = s_axis_tvalid && s_axis_tready;
            popped = m_axis_tvalid && m_axis_tready;
            if (pushed && bram_addra == AW'(31)) wraps++;
            if (popped) begin
                if (first < 0) first = cyc;
                last = cyc;
                recv++;
            end
            tick();
            if (pushed) sent++;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        chk("stream_recv", 32'(recv), 32'd100);
        chk("stream_latency", 32'(first), 32'd3);
        chk("stream_no_gaps", 32'(last - first), 32'd99);
        chk("stream_wraps", 32'(wraps >= 3), 32'd1);

        // Random backpressure
        sent = 0; cyc = 0; dat = DW'($urandom);
        while (sent < 1000 && cyc < 20000) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = dat;
            m_axis_tready = 1'($urandom_range(0, 1));
            #0;
            pushed = s_axis_tvalid && s_axis_tready;
            tick();
            if (pushed) begin
                sent++;
                dat = DW'($urandom);
            end
            cyc++;
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        chk("random_sent", 32'(sent), 32'd1000);
        wait_empty(200);
        chk("random_level_0", 32'(level), 32'd0);

        // Reset in the middle of operation
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(16'h0E00 + i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        chk("pre_reset_level", 32'(level), 32'd10);
        #2 reset = 1'b1;
        #1;
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_s_tready", 32'(s_axis_tready), 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'h1234;
        n = 0;
        while (!s_axis_tready && n < 5) begin tick(); n++; end
        tick();
        s_axis_tvalid = 1'b0;
        n = 0;
        while (!m_axis_tvalid && n < 10) begin tick(); n++; end
        chk("post_reset_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("post_reset_tdata", 32'(m_axis_tdata), 32'h1234);
        wait_empty(50);

        // Full FIFO, then pop while upstream keeps pushing
        m_axis_tready = 1'b0; dat = 16'h2000; n = 0;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready && n < 60) begin
            s_axis_tdata = dat;
            tick();
            dat++;
            n++;
        end
        s_axis_tdata = dat;
        chk("full_level", 32'(level), 32'd34);
        chk("full_s_tready", 32'(s_axis_tready), 32'd0);
        m_axis_tready = 1'b1;
        tick();
        n = 1;
        while (!s_axis_tready && n < 5) begin tick(); n++; end
        chk("ready_reassert", 32'(n <= 2), 32'd1);
        for (int i = 0; i < 30; i++) begin
            pushed = s_axis_tready;
            tick();
            if (pushed) begin
                dat++;
                s_axis_tdata = dat;
            end
            chk("level_band", 32'(level >= 33 && level <= 34), 32'd1);
        end
        s_axis_tvalid = 1'b0;
        wait_empty(100);
        chk("final_level", 32'(level), 32'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/axis_fifo_bram_ctrl.md
Name: axis_fifo_bram_ctrl

Overview:
- Single-clock AXI-Stream FIFO controller that sequences an external simple dual-port BRAM (write port A, registered read port B with 1-cycle read latency).
- The BRAM's clka and clkb are both tied to clk at the parent.
- The controller owns the write/read pointers, occupancy accounting, read issue and a 2-entry output buffer that hides read latency, so a full one-word-per-cycle stream is sustained.
- Used wherever the design needs deep BRAM-backed stream buffering in one clock domain.

Parameters:
- DATA_WIDTH, 16, stream and BRAM word width.
- ADDRESS_WIDTH, 5, BRAM address width; RAM depth D = 2**ADDRESS_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  upstream word valid.
- s_axis_tready  out  1  controller accepts upstream word.
- s_axis_tdata  in  DATA_WIDTH  upstream word.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream accepts output word.
- m_axis_tdata  out  DATA_WIDTH  output word.
- bram_wea  out  1  BRAM write enable.
- bram_addra  out  ADDRESS_WIDTH  BRAM write address.
- bram_dina  out  DATA_WIDTH  BRAM write data.
- bram_reb  out  1  BRAM read enable.
- bram_addrb  out  ADDRESS_WIDTH  BRAM read address.
- bram_doutb  in  DATA_WIDTH  BRAM read data, valid the cycle after bram_reb.
- level  out  ADDRESS_WIDTH+2  total words held (RAM + in-flight + output buffer), 0..D+2.

Behaviour:
- Reset (async, immediate):
  - wr_ptr = rd_ptr = 0; ram_count = 0; in-flight flag = 0; output buffer empty.
  - m_axis_tvalid = 0; s_axis_tready = 0 while reset is high; level = 0.
  - bram_wea = bram_reb = 0 combinationally while in reset.
  - Stored contents are discarded.
  - s_axis_tready = 1 on the first edge after reset deasserts.
- Write side:
  - s_axis_tready = registered ~ram_full, where ram_full = (ram_count == D). ram_count is ADDRESS_WIDTH+1 bits.
  - s_axis_tready has no combinational path from m_axis_tready.
  - Push = s_axis_tvalid & s_axis_tready.
  - On push, combinationally: bram_wea = 1, bram_addra = wr_ptr, bram_dina = s_axis_tdata.
  - wr_ptr increments modulo D at the edge.
- Read issue:
  - bram_reb = (ram_count > 0) & (out_cnt + inflight - pop < 2), where pop = m_axis_tvalid & m_axis_tready.
  - bram_addrb = rd_ptr; rd_ptr increments modulo D on issue.
  - inflight is set on the edge after issue. Returned bram_doutb is written into the output buffer on the next edge.
- ram_count update: +1 on push, -1 on issue, unchanged when both occur in the same cycle.
- Read-during-write avoidance:
  - The BRAM has no read-during-write guarantee, so the controller never reads an address in the same cycle it is written.
  - Reads only target committed entries (counted after the write edge), and writes are blocked when the RAM is full. Together these guarantee addra != addrb whenever wea & reb.
- Output buffer:
  - 2-entry FIFO (head and skid).
  - m_axis_tdata is driven from the head register, never combinationally from bram_doutb.
  - m_axis_tvalid = (out_cnt > 0).
  - A simultaneous pop and fill keeps ordering; the skid entry moves to the head on pop.
  - While tvalid & !tready, tdata is held stable.
- Latency:
  - Push at edge E0 into an empty FIFO gives reb during cycle E0..E1, data captured at E2, m_axis_tvalid high after E2 (3 edges).
  - Steady state: 1 word/cycle in each direction with no bubbles when both sides are ready.
- Capacity: D + 2 words. s_axis_tready falls only when the RAM holds D words.
- level: registered and updated every edge as level + push - pop.
- Pointer wrap: pointers wrap D-1 -> 0 silently; ordering is preserved across the wrap.

Test Plan (DATA_WIDTH=16, ADDRESS_WIDTH=5, D=32):
- Single word: push 0xA5A5 at edge E0 with m_axis_tready=1 -> m_axis_tvalid rises after E2 with tdata 0xA5A5; level goes 1 then 0 after the pop; s_axis_tready stays 1.
- Fill: m_axis_tready=0, drive s_axis_tvalid=1 with data 0..39 -> exactly 34 words accepted (0..33), s_axis_tready=0, level=34. Then set m_axis_tready=1 -> words 0..33 emerge in order and s_axis_tready returns to 1.
- Streaming: both sides ready, 100 sequential words -> after the 3-cycle latency, one output per cycle with no gaps; rd_ptr/wr_ptr wrap 31 -> 0 at least 3 times; data in order.
- Random backpressure: 1000 random words with ~50% random tvalid/tready -> scoreboard exact match. Assertions:
  - no wea&reb with addra==addrb;
  - tdata stable while stalled;
  - level always equals the scoreboard depth.
- Reset mid-operation: 10 words stored, assert reset for 1 cycle mid-clock -> m_axis_tvalid=0 and level=0 immediately, s_axis_tready=0 during reset. After release, push 0x1234 -> first output is 0x1234 with no stale data.
- Full plus pop: FIFO at level 34, pop one word per cycle while upstream pushes continuously -> s_axis_tready re-asserts within 2 cycles of the first pop, level settles at 33–34, no data lost or duplicated.
